// File: rtl/friet_permutation_sequencer.sv
// Word-serial load / iterate / unload controller for an external combinational
// Friet round datapath computing COMBINATIONAL_ROUNDS rounds per clock.
module friet_permutation_sequencer #(
  parameter int unsigned STATE_SIZE           = 384,
  parameter int unsigned WORD_SIZE            = 32,
  parameter int unsigned COMBINATIONAL_ROUNDS = 2,
  parameter int unsigned MAX_ROUNDS           = 24,
  parameter int unsigned ROUND_WIDTH          = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_SIZE-1:0]   din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [WORD_SIZE-1:0]   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  input  logic                   start,
  input  logic [ROUND_WIDTH-1:0] start_rounds,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [STATE_SIZE-1:0]  dp_state,
  output logic [ROUND_WIDTH-1:0] dp_round_index,
  input  logic [STATE_SIZE-1:0]  dp_new_state
);

  localparam int unsigned NUM_WORDS = STATE_SIZE / WORD_SIZE;
  localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CNT_W-1:0]       LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [ROUND_WIDTH-1:0] MAX_R     = ROUND_WIDTH'(MAX_ROUNDS);
  localparam logic [ROUND_WIDTH-1:0] STEP      = ROUND_WIDTH'(COMBINATIONAL_ROUNDS);
  localparam logic [ROUND_WIDTH:0]   STEP_WIDE = (ROUND_WIDTH + 1)'(COMBINATIONAL_ROUNDS);

  typedef enum logic [1:0] {
    LOAD,
    FULL,
    RUN,
    UNLOAD
  } seq_state_t;

  seq_state_t             fsm;
  logic [STATE_SIZE-1:0]  state_q;
  logic [CNT_W-1:0]       word_cnt;
  logic [ROUND_WIDTH-1:0] round_cnt;
  logic [ROUND_WIDTH-1:0] rounds_lat;
  logic                   start_legal;
  logic                   last_word;
  logic [ROUND_WIDTH:0]   round_next;

  always_comb begin
    start_legal = (start_rounds != '0) && (start_rounds <= MAX_R) &&
                  ((start_rounds % STEP) == '0);
    last_word   = (word_cnt == LAST_WORD);
    // One extra bit so the terminal comparison never wraps.
    round_next  = {1'b0, round_cnt} + STEP_WIDE;
  end

  // round_cnt is cleared whenever RUN is left, so it doubles as dp_round_index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= LOAD;
      state_q    <= '0;
      word_cnt   <= '0;
      round_cnt  <= '0;
      rounds_lat <= '0;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (fsm)
        LOAD: begin
          if (start) error <= 1'b1;
          if (din_valid) begin
            state_q <= {din, state_q[STATE_SIZE-1:WORD_SIZE]};
            if (last_word) begin
              word_cnt  <= '0;
              fsm       <= FULL;
              din_ready <= 1'b0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (start) begin
            if (start_legal) begin
              fsm        <= RUN;
              busy       <= 1'b1;
              round_cnt  <= '0;
              rounds_lat <= start_rounds;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RUN: begin
          state_q <= dp_new_state;
          if (round_next == {1'b0, rounds_lat}) begin
            fsm        <= UNLOAD;
            busy       <= 1'b0;
            done       <= 1'b1;
            dout_valid <= 1'b1;
            round_cnt  <= '0;
          end else begin
            round_cnt <= round_next[ROUND_WIDTH-1:0];
          end
        end
        UNLOAD: begin
          if (dout_ready) begin
            if (last_word) begin
              state_q    <= '0;
              word_cnt   <= '0;
              fsm        <= LOAD;
              dout_valid <= 1'b0;
              din_ready  <= 1'b1;
            end else begin
              state_q  <= {{WORD_SIZE{1'b0}}, state_q[STATE_SIZE-1:WORD_SIZE]};
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: fsm <= LOAD;
      endcase
    end
  end

  assign dout           = state_q[WORD_SIZE-1:0];
  assign dp_state       = state_q;
  assign dp_round_index = round_cnt;

endmodule

// File: tb/tb_friet_permutation_sequencer.sv
// Randomized bench for friet_permutation_sequencer with a stub round datapath
// and a reference permutation model computed from the round rules.
module tb_friet_permutation_sequencer;

  localparam int unsigned C = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  din;
  logic         din_valid;
  logic         din_ready;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         start;
  logic [4:0]   start_rounds;
  logic         busy;
  logic         done;
  logic         error;
  logic [383:0] dp_state;
  logic [4:0]   dp_round_index;
  logic [383:0] dp_new_state;
  logic         stub_xor;
  logic [383:0] idx_term;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  words [12];
  logic [383:0] loaded;

  friet_permutation_sequencer #(
    .STATE_SIZE(384),
    .WORD_SIZE(32),
    .COMBINATIONAL_ROUNDS(C),
    .MAX_ROUNDS(24),
    .ROUND_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .start(start),
    .start_rounds(start_rounds),
    .busy(busy),
    .done(done),
    .error(error),
    .dp_state(dp_state),
    .dp_round_index(dp_round_index),
    .dp_new_state(dp_new_state)
  );

  always #5 clk = ~clk;

  // Stub datapath: plain XOR of the round index, or rotate-then-XOR so that
  // round order and count both show up in the result.
  assign idx_term     = {372'b0, dp_round_index, 7'b0};
  assign dp_new_state = stub_xor ? (dp_state ^ idx_term)
                                 : ({dp_state[382:0], dp_state[383]} ^ idx_term);

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] ref_perm(input logic [383:0] s_in, input int unsigned rounds,
                                            input logic xor_only);
    logic [383:0] s;
    logic [383:0] t;
    s = s_in;
    for (int unsigned r = 0; r < rounds; r += C) begin
      t = 384'(r) << 7;
      s = xor_only ? (s ^ t) : ({s[382:0], s[383]} ^ t);
    end
    return s;
  endfunction

  function automatic logic legal_rounds(input int unsigned r);
    return (r != 0) && (r <= 24) && (r % C == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_words();
    for (int i = 0; i < 12; i++) begin
      words[i] = $urandom;
      loaded[i*32 +: 32] = words[i];
    end
  endtask

  task automatic load_words(input int first, input int last, input logic gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          din_valid = 1'b0;
          din = $urandom;
          tick();
        end
      end
      din = words[i];
      din_valid = 1'b1;
      check("load_din_ready", din_ready, 1'b1);
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic do_start(input int unsigned r);
    start = 1'b1;
    start_rounds = 5'(r);
    tick();
    start = 1'b0;
  endtask

  task automatic run_and_unload(input int unsigned rounds, input logic [383:0] exp,
                                input logic inject);
    int cnt;
    int idx;
    int guard;
    cnt = 0;
    while (busy && cnt < 40) begin
      check("round_index", dp_round_index, cnt * C);
      check("run_error", error, 1'b0);
      check("run_din_ready", din_ready, 1'b0);
      if (inject && cnt == 1) begin
        start = 1'b1;
        start_rounds = 5'd2;
      end
      tick();
      start = 1'b0;
      cnt++;
    end
    check("busy_cycles", cnt, rounds / C);
    check("done_pulse", done, 1'b1);
    check("first_dout_valid", dout_valid, 1'b1);
    check("idle_round_index", dp_round_index, 0);
    idx = 0;
    guard = 0;
    while (idx < 12 && guard < 300) begin
      dout_ready = 1'($urandom_range(0, 1));
      din_valid = 1'($urandom_range(0, 1));
      din = $urandom;
      start = (inject && guard == 3);
      check("unload_valid", dout_valid, 1'b1);
      check("unload_word", dout, exp[idx*32 +: 32]);
      check("unload_error", error, 1'b0);
      check("unload_din_ready", din_ready, 1'b0);
      if (guard > 0) check("done_once", done, 1'b0);
      tick();
      if (dout_ready) idx++;
      guard++;
    end
    dout_ready = 1'b0;
    din_valid = 1'b0;
    start = 1'b0;
    check("unload_count", idx, 12);
    check("post_error", error, 1'b0);
    check("post_dout_valid", dout_valid, 1'b0);
    check("post_din_ready", din_ready, 1'b1);
    check("post_state_clear", dp_state, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din_ready"}, din_ready, 1'b1);
    check({tag, "_dout_valid"}, dout_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_round_index"}, dp_round_index, 0);
    check({tag, "_state"}, dp_state, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    int cnt;
    int unsigned bad_r [4] = '{23, 0, 26, 3};
    logic [383:0] snap;

    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    start = 1'b0;
    start_rounds = '0;
    stub_xor = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reduced rounds with the XOR stub: indices 0 then 2.
    new_words();
    load_words(0, 11, 1'b1);
    check("full_state", dp_state, loaded);
    check("full_din_ready", din_ready, 1'b0);
    do_start(4);
    run_and_unload(4, ref_perm(loaded, 4, 1'b1), 1'b0);

    // Full 24-round run with the rotating stub.
    stub_xor = 1'b0;
    new_words();
    load_words(0, 11, 1'b0);
    do_start(24);
    run_and_unload(24, ref_perm(loaded, 24, 1'b0), 1'b0);

    // Illegal start during a partial load, then illegal starts in FULL.
    new_words();
    load_words(0, 4, 1'b0);
    do_start(24);
    check("load_start_error", error, 1'b1);
    check("load_start_din_ready", din_ready, 1'b1);
    tick();
    check("load_start_error_clear", error, 1'b0);
    load_words(5, 11, 1'b1);
    check("partial_then_full", dp_state, loaded);
    foreach (bad_r[i]) begin
      check("model_illegal", legal_rounds(bad_r[i]), 1'b0);
      do_start(bad_r[i]);
      check("full_bad_error", error, 1'b1);
      check("full_bad_busy", busy, 1'b0);
      check("full_bad_din_ready", din_ready, 1'b0);
      check("full_bad_state", dp_state, loaded);
      tick();
      check("full_bad_error_clear", error, 1'b0);
    end
    do_start(24);
    run_and_unload(24, ref_perm(loaded, 24, 1'b0), 1'b1);

    // Reset on the sixth RUN cycle.
    new_words();
    load_words(0, 11, 1'b0);
    do_start(24);
    cnt = 0;
    while (busy && cnt < 5) begin
      tick();
      cnt++;
    end
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) begin
      tick();
      check("reset_no_output", dout_valid, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_reset_outputs("after_reset");
    new_words();
    load_words(0, 11, 1'b1);
    do_start(24);
    run_and_unload(24, ref_perm(loaded, 24, 1'b0), 1'b0);

    // Randomized legal runs.
    for (int n = 0; n < 6; n++) begin
      stub_xor = 1'($urandom_range(0, 1));
      r = C * $urandom_range(1, 24 / C);
      new_words();
      load_words(0, 11, 1'($urandom_range(0, 1)));
      do_start(r);
      run_and_unload(r, ref_perm(loaded, r, stub_xor), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
